// File: rtl/regfile_port_scheduler_if.sv
// Bundle of handshake and register-file signals around regfile_port_scheduler.
// slave  : the scheduler's view (takes requests, drives the register file).
// master : the surrounding pipeline / register file view.
interface regfile_port_scheduler_if #(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 5
);
    // operand-fetch read request and its response
    logic                    rd_valid;
    logic [ADDR_WIDTH_P-1:0] rd_addr_a;
    logic [ADDR_WIDTH_P-1:0] rd_addr_b;
    logic                    rd_ready;
    logic                    rsp_valid;
    logic [DATA_WIDTH_P-1:0] rsp_data_a;
    logic [DATA_WIDTH_P-1:0] rsp_data_b;

    // writeback source 0 (ALU)
    logic                    wb0_valid;
    logic [ADDR_WIDTH_P-1:0] wb0_addr;
    logic [DATA_WIDTH_P-1:0] wb0_data;
    logic                    wb0_ready;

    // writeback source 1 (load unit)
    logic                    wb1_valid;
    logic [ADDR_WIDTH_P-1:0] wb1_addr;
    logic [DATA_WIDTH_P-1:0] wb1_data;
    logic                    wb1_ready;

    // register file control and read data
    logic [ADDR_WIDTH_P-1:0] rf_rd_addr_a;
    logic [ADDR_WIDTH_P-1:0] rf_rd_addr_b;
    logic [ADDR_WIDTH_P-1:0] rf_wr_addr;
    logic [DATA_WIDTH_P-1:0] rf_wr_data;
    logic                    rf_wr_enable;
    logic [DATA_WIDTH_P-1:0] rf_rd_data_a;
    logic [DATA_WIDTH_P-1:0] rf_rd_data_b;

    modport slave (
        input  rd_valid, rd_addr_a, rd_addr_b,
        output rd_ready, rsp_valid, rsp_data_a, rsp_data_b,
        input  wb0_valid, wb0_addr, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_addr, wb1_data,
        output wb1_ready,
        output rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, rf_wr_data, rf_wr_enable,
        input  rf_rd_data_a, rf_rd_data_b
    );

    modport master (
        output rd_valid, rd_addr_a, rd_addr_b,
        input  rd_ready, rsp_valid, rsp_data_a, rsp_data_b,
        output wb0_valid, wb0_addr, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_addr, wb1_data,
        input  wb1_ready,
        input  rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, rf_wr_data, rf_wr_enable,
        output rf_rd_data_a, rf_rd_data_b
    );
endinterface

// File: rtl/regfile_port_scheduler.sv
// Port scheduler for a 2-read/1-write register file.
// Shares the single write port between WB0 (ALU) and WB1 (load unit) with
// round-robin arbitration, and places read requests into write-free cycles.
// A read that has watched STARVE_LIMIT_P consecutive write grants is forced
// through on the next cycle, so reads get at least 1 of every
// STARVE_LIMIT_P+1 cycles under saturating traffic.
//
// Optional feature macro: REGFILE_SCHED_ZERO_REG_EN
//   defined   : register 0 is hardwired to zero. Writes to r0 complete their
//               handshake but never assert the register-file write enable;
//               read data for a captured address of 0 is forced to zero.
//   undefined : register 0 is an ordinary register.
module regfile_port_scheduler #(
    parameter int DATA_WIDTH_P   = 32,
    parameter int ADDR_WIDTH_P   = 5,
    parameter int STARVE_LIMIT_P = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    regfile_port_scheduler_if.slave    bus
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT_P + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT_P);

    // one grant per cycle; GNT_NONE also covers the reset cycles
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WB0  = 2'd2,
        GNT_WB1  = 2'd3
    } grant_e;

    grant_e              grant;
    logic                wr_grant;
    logic                starve_hit;
    logic [STARVE_W-1:0] starve_cnt;
    logic                rr_last;      // index of the last granted writeback
    logic                rsp_valid_q;

    assign starve_hit = (starve_cnt == STARVE_MAX) && bus.rd_valid;
    assign wr_grant   = (grant == GNT_WB0) || (grant == GNT_WB1);

    // arbitration: starved read, then writes (round-robin on a tie), then read
    always_comb begin
        grant = GNT_NONE;
        if (!reset) begin
            if (starve_hit) begin
                grant = GNT_RD;
            end else if (bus.wb0_valid && bus.wb1_valid) begin
                grant = rr_last ? GNT_WB0 : GNT_WB1;
            end else if (bus.wb0_valid) begin
                grant = GNT_WB0;
            end else if (bus.wb1_valid) begin
                grant = GNT_WB1;
            end else if (bus.rd_valid) begin
                grant = GNT_RD;
            end
        end
    end

    // handshake readies and register-file write port driven from the grant
    always_comb begin
        bus.rd_ready     = (grant == GNT_RD);
        bus.wb0_ready    = (grant == GNT_WB0);
        bus.wb1_ready    = (grant == GNT_WB1);
        bus.rf_wr_addr   = '0;
        bus.rf_wr_data   = '0;
        bus.rf_wr_enable = 1'b0;
        if (grant == GNT_WB0) begin
            bus.rf_wr_addr = bus.wb0_addr;
            bus.rf_wr_data = bus.wb0_data;
        end else if (grant == GNT_WB1) begin
            bus.rf_wr_addr = bus.wb1_addr;
            bus.rf_wr_data = bus.wb1_data;
        end
`ifdef REGFILE_SCHED_ZERO_REG_EN
        // r0 writes are swallowed: handshake completes, the file never updates
        bus.rf_wr_enable = wr_grant && (bus.rf_wr_addr != '0);
`else
        bus.rf_wr_enable = wr_grant;
`endif
    end

    // read addresses go straight through; the file only uses them on write-free cycles
    assign bus.rf_rd_addr_a = bus.rd_addr_a;
    assign bus.rf_rd_addr_b = bus.rd_addr_b;

    // starvation counter, round-robin pointer and response-valid flag
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt  <= '0;
            rr_last     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= (grant == GNT_RD);
            if (grant == GNT_WB0) begin
                rr_last <= 1'b0;
            end else if (grant == GNT_WB1) begin
                rr_last <= 1'b1;
            end
            if (!bus.rd_valid || (grant == GNT_RD)) begin
                starve_cnt <= '0;
            end else if (wr_grant && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

    // gating with reset suppresses a response whose grant came just before reset
    assign bus.rsp_valid = rsp_valid_q && !reset;

`ifdef REGFILE_SCHED_ZERO_REG_EN
    logic [ADDR_WIDTH_P-1:0] rsp_addr_a_q;
    logic [ADDR_WIDTH_P-1:0] rsp_addr_b_q;

    // remember which registers the pending response belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_addr_a_q <= '0;
            rsp_addr_b_q <= '0;
        end else if (grant == GNT_RD) begin
            rsp_addr_a_q <= bus.rd_addr_a;
            rsp_addr_b_q <= bus.rd_addr_b;
        end
    end

    assign bus.rsp_data_a = (rsp_addr_a_q == '0) ? '0 : bus.rf_rd_data_a;
    assign bus.rsp_data_b = (rsp_addr_b_q == '0) ? '0 : bus.rf_rd_data_b;
`else
    assign bus.rsp_data_a = bus.rf_rd_data_a;
    assign bus.rsp_data_b = bus.rf_rd_data_b;
`endif

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Directed bench for regfile_port_scheduler with a behavioural 2R1W register
// file attached. Read responses are predicted from a shadow copy of the
// registers and checked through a scoreboard queue.
// Honours REGFILE_SCHED_ZERO_REG_EN when built with the same define as the RTL.
module tb_regfile_port_scheduler;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic [DW-1:0] shadow [32];
    logic [DW-1:0] rf_mem [32];
    int   waits;

    regfile_port_scheduler_if #(.DATA_WIDTH_P(DW), .ADDR_WIDTH_P(AW)) ifc ();

    regfile_port_scheduler #(
        .DATA_WIDTH_P  (DW),
        .ADDR_WIDTH_P  (AW),
        .STARVE_LIMIT_P(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // register file model: clears on reset, read outputs update only on write-free cycles
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
            ifc.rf_rd_data_a <= '0;
            ifc.rf_rd_data_b <= '0;
        end else if (ifc.rf_wr_enable) begin
            rf_mem[ifc.rf_wr_addr] <= ifc.rf_wr_data;
        end else begin
            ifc.rf_rd_data_a <= rf_mem[ifc.rf_rd_addr_a];
            ifc.rf_rd_data_b <= rf_mem[ifc.rf_rd_addr_b];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit zero_reg_en();
`ifdef REGFILE_SCHED_ZERO_REG_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void shadow_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (!(zero_reg_en() && addr == '0)) shadow[addr] = data;
    endfunction

    // response checker: pop the oldest prediction whenever a response appears
    always @(negedge clk) begin
        if (!reset && ifc.rsp_valid) begin
            exp_t e;
            if (sb.size() != 0) begin
                e = sb.pop_front();
            end else begin
                e.due  = -1;
                e.data = 'x;
            end
            chk("rsp_data", {ifc.rsp_data_a, ifc.rsp_data_b}, e.data);
            chk("rsp_cycle", 64'(cyc), 64'(e.due));
        end
    end

    task automatic clear_inputs();
        ifc.rd_valid  = 1'b0; ifc.rd_addr_a = '0; ifc.rd_addr_b = '0;
        ifc.wb0_valid = 1'b0; ifc.wb0_addr  = '0; ifc.wb0_data  = '0;
        ifc.wb1_valid = 1'b0; ifc.wb1_addr  = '0; ifc.wb1_data  = '0;
    endtask

    // hold reset for a few cycles with every request raised; nothing may be accepted
    task automatic do_reset(input string tag);
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        ifc.rd_valid = 1'b1; ifc.wb0_valid = 1'b1; ifc.wb1_valid = 1'b1;
        ifc.wb0_addr = 5'd4; ifc.wb1_addr = 5'd6;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk({tag, "_rd_ready"},  ifc.rd_ready, 0);
            chk({tag, "_wb0_ready"}, ifc.wb0_ready, 0);
            chk({tag, "_wb1_ready"}, ifc.wb1_ready, 0);
            chk({tag, "_wr_enable"}, ifc.rf_wr_enable, 0);
            chk({tag, "_rsp_valid"}, ifc.rsp_valid, 0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic do_write(input int src, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit got = 1'b0;
        if (src == 0) begin
            ifc.wb0_valid = 1'b1; ifc.wb0_addr = addr; ifc.wb0_data = data;
        end else begin
            ifc.wb1_valid = 1'b1; ifc.wb1_addr = addr; ifc.wb1_data = data;
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if ((src == 0) ? ifc.wb0_ready : ifc.wb1_ready) begin
                got = 1'b1;
                chk("wr_enable", ifc.rf_wr_enable, (zero_reg_en() && addr == '0) ? 0 : 1);
                chk("wr_addr", ifc.rf_wr_addr, addr);
                chk("wr_data", ifc.rf_wr_data, data);
                shadow_write(addr, data);
            end
            @(posedge clk); #1;
        end
        chk("wr_accept", got, 1);
        ifc.wb0_valid = 1'b0;
        ifc.wb1_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b, output int nwait);
        bit   got = 1'b0;
        exp_t e;
        nwait = 0;
        ifc.rd_valid = 1'b1; ifc.rd_addr_a = a; ifc.rd_addr_b = b;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (ifc.rd_ready) begin
                got = 1'b1;
                chk("rf_rd_addr_a", ifc.rf_rd_addr_a, a);
                chk("rf_rd_addr_b", ifc.rf_rd_addr_b, b);
                chk("rd_wr_enable", ifc.rf_wr_enable, 0);
                e.due  = cyc + 1;
                e.data = {shadow[a], shadow[b]};
                sb.push_back(e);
            end else begin
                nwait++;
            end
            @(posedge clk); #1;
        end
        chk("rd_accept", got, 1);
        ifc.rd_valid = 1'b0;
    endtask

    initial begin
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        // idle: nothing granted, write port parked at zero
        @(negedge clk);
        chk("idle_rd_ready", ifc.rd_ready, 0);
        chk("idle_wr_enable", ifc.rf_wr_enable, 0);
        chk("idle_wr_addr", ifc.rf_wr_addr, 0);
        chk("idle_wr_data", ifc.rf_wr_data, 0);
        @(posedge clk); #1;

        // single read after two writes
        do_write(0, 5'd3, 32'hA5);
        do_write(1, 5'd7, 32'h5A);
        do_read(5'd3, 5'd7, waits);
        chk("read1_wait", waits, 0);

        // both writebacks held: WB1 first, then alternate
        do_reset("reset2");
        ifc.wb0_valid = 1'b1; ifc.wb0_addr = 5'd1; ifc.wb0_data = 32'h11;
        ifc.wb1_valid = 1'b1; ifc.wb1_addr = 5'd2; ifc.wb1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_wb1_ready", ifc.wb1_ready, (i % 2 == 0));
            chk("rr_wb0_ready", ifc.wb0_ready, (i % 2 == 1));
            chk("rr_wr_enable", ifc.rf_wr_enable, 1);
            chk("rr_wr_addr", ifc.rf_wr_addr, (i % 2 == 0) ? 2 : 1);
            if (ifc.wb0_ready) shadow_write(ifc.wb0_addr, ifc.wb0_data);
            if (ifc.wb1_ready) shadow_write(ifc.wb1_addr, ifc.wb1_data);
            @(posedge clk); #1;
        end

        // saturating traffic: 4 write grants then one forced read, repeating
        ifc.rd_valid = 1'b1; ifc.rd_addr_a = 5'd1; ifc.rd_addr_b = 5'd2;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("sv_rd_ready", ifc.rd_ready, (i % 5 == 4));
            chk("sv_wb1_ready", ifc.wb1_ready, (i % 5 == 0) || (i % 5 == 2));
            chk("sv_wb0_ready", ifc.wb0_ready, (i % 5 == 1) || (i % 5 == 3));
            chk("sv_wr_enable", ifc.rf_wr_enable, (i % 5 != 4));
            if (ifc.rd_ready) begin
                exp_t e;
                e.due  = cyc + 1;
                e.data = {shadow[1], shadow[2]};
                sb.push_back(e);
            end
            if (ifc.wb0_ready) shadow_write(ifc.wb0_addr, ifc.wb0_data);
            if (ifc.wb1_ready) shadow_write(ifc.wb1_addr, ifc.wb1_data);
            @(posedge clk); #1;
        end
        clear_inputs();

        // read immediately after write to the same register sees the new value
        do_write(0, 5'd9, 32'h1234);
        do_read(5'd9, 5'd9, waits);
        chk("raw_wait", waits, 0);

        // reset one cycle after a read grant: no response, file cleared
        do_read(5'd9, 5'd1, waits);
        do_reset("reset3");
        do_read(5'd9, 5'd1, waits);

        // writes to r0 (hardwired zero only when the feature is built in)
        do_write(0, 5'd3, 32'hA5);
        do_write(0, 5'd0, 32'hFFFF);
        do_read(5'd0, 5'd3, waits);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // absolute guard so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_port_scheduler.md
# regfile_port_scheduler

Sequencing front-end for the 2-read/1-write register file. Shares the single write port between two writeback sources (WB0 = ALU, WB1 = load unit) with round-robin arbitration. Because the register file only updates its read outputs on cycles with no write, the block also schedules read requests into write-free cycles, with a starvation limit protecting reads. It sits between decode/writeback and the register file and drives every register-file control input.

## Interface
- DATA_WIDTH_P, 32, register data width
- ADDR_WIDTH_P, 5, register address width
- STARVE_LIMIT_P, 4, consecutive write grants tolerated while a read is pending (≥1)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_rd_valid  in  1  read request (operand fetch)
- i_rd_addr_a, i_rd_addr_b  in  ADDR_WIDTH_P  read addresses
- o_rd_ready  out  1  read request accepted this cycle
- o_rsp_valid  out  1  read data valid (no backpressure)
- o_rsp_data_a, o_rsp_data_b  out  DATA_WIDTH_P  read data
- i_wb0_valid, i_wb1_valid  in  1  writeback requests
- i_wb0_addr, i_wb1_addr  in  ADDR_WIDTH_P  destination registers
- i_wb0_data, i_wb1_data  in  DATA_WIDTH_P  writeback data
- o_wb0_ready, o_wb1_ready  out  1  writeback accepted this cycle
- o_rf_rd_addr_a, o_rf_rd_addr_b, o_rf_wr_addr  out  ADDR_WIDTH_P  to register file
- o_rf_wr_data  out  DATA_WIDTH_P  to register file
- o_rf_wr_enable  out  1  to register file
- i_rf_rd_data_a, i_rf_rd_data_b  in  DATA_WIDTH_P  from register file

## Operation
- Handshakes are valid/ready. Transfer happens when valid && ready. Valid and payload hold until accepted.
- Each cycle, exactly one of these is granted: read, WB0, WB1, or nothing.
- Grant priority:
  - If starve_cnt == STARVE_LIMIT_P and i_rd_valid, grant the read.
  - Otherwise a pending write wins.
  - If both writebacks are valid, grant the one not granted last (rr_last register, 1 bit, reset 0 so WB1 wins the first tie).
  - If only one writeback is valid, grant it.
  - With no write pending, grant the read if i_rd_valid.
- rr_last updates to the granted index on every write grant.
- starve_cnt behaviour:
  - Increments, saturating at STARVE_LIMIT_P, on each write grant while i_rd_valid = 1.
  - Clears on a read grant or whenever i_rd_valid = 0.
  - Width is clog2(STARVE_LIMIT_P+1).
- Write grant:
  - o_rf_wr_enable = 1.
  - o_rf_wr_addr/o_rf_wr_data = the granted source's payload.
  - That source's ready = 1.
- Read grant:
  - o_rf_wr_enable = 0 and o_rd_ready = 1.
  - o_rf_rd_addr_a/b = i_rd_addr_a/b.
- o_rf_rd_addr_a/b always follow i_rd_addr_a/b, and o_rf_wr_* are zero when no write is granted.
- o_rsp_valid is a register, set in the cycle after a read grant.
- o_rsp_data_a/b = i_rf_rd_data_a/b (passthrough).
- A read granted the cycle after a write to the same register returns the new value. The write lands at that edge, so no bypass is needed.
- Same-address WB0/WB1 requests are serialized in grant order; the last one granted persists.

## Timing
- Grant, ready and o_rf_* outputs are combinational from inputs and state. The register file samples them at the next edge.
- Read latency is 1 cycle: grant in cycle N, o_rsp_valid/data in cycle N+1.
- Throughput is one operation per cycle. Under continuous read and write traffic, reads get at least 1 of every STARVE_LIMIT_P+1 cycles.
- During reset:
  - All readies = 0, o_rf_wr_enable = 0, o_rsp_valid = 0.
  - starve_cnt = 0 and rr_last = 0.
  - The register file clears concurrently.
- The first grant is possible in the cycle after reset deasserts.
- A read granted in the cycle before reset is asserted produces no response. reset clears o_rsp_valid.

## Configuration
- REGFILE_SCHED_ZERO_REG_EN defined:
  - A granted write to address 0 still completes its handshake (ready = 1 and rr_last updates).
  - o_rf_wr_enable is held 0, and o_rsp_data_a/b read as 0 when the corresponding captured address was 0.
  - The captured addresses are registered on read grant.
  - The cycle is treated as write-free, but the read is not granted alongside it.
- Undefined: address 0 is an ordinary register.

## Test plan
- Single read, addr_a=3, addr_b=7, after writes r3=0xA5, r7=0x5A: o_rd_ready in cycle N, o_rsp_valid with data 0xA5/0x5A in N+1.
- WB0 and WB1 held valid continuously after reset: grants go WB1, WB0, WB1, WB0; o_rf_wr_enable=1 every cycle.
- STARVE_LIMIT_P=4, reads and both writebacks continuously valid: exactly 4 write grants, then 1 read grant, repeating; no read waits more than 5 cycles.
- Write r9=0x1234 in cycle N, read r9 in N+1: response in N+2 is 0x1234.
- Reset asserted one cycle after a read grant: o_rsp_valid stays 0, all readies are 0 during reset, and reads return 0 afterward.
- With REGFILE_SCHED_ZERO_REG_EN, WB0 writes 0xFFFF to r0: o_wb0_ready=1, o_rf_wr_enable=0, and a subsequent read of r0 returns 0. Without the macro, the read returns 0xFFFF.
